// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: four-state fetch sequencer (IDLE -> REQ -> WAIT -> LOAD).
// Issues a one-cycle read strobe at the current pc, waits for the memory to
// answer, and hands the word to the instruction register with a one-cycle
// load pulse. Branches redirect the pc immediately in IDLE/LOAD. In REQ/WAIT
// they are parked until the outstanding read retires, and that read's data
// is then dropped.
// Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch after
// TIMEOUT_CYCLES silent WAIT cycles (fetch_error pulses for one cycle).
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic        mem_rd_valid,
  input  logic [15:0] mem_rd_data,
  output logic [15:0] instr_out,
  output logic        ir_load_enable,
  output logic [15:0] pc_out,
  output logic        fetch_busy,
  output logic        fetch_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, LOAD} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] instr_reg, instr_next;
  logic        pend_reg, pend_next;
  logic [15:0] tgt_reg, tgt_next;
  logic        mem_rd_en_reg;
  logic        ir_load_reg;
  logic        busy_reg;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
`else
  // The timeout limit has no meaning without the counter.
  logic        unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  // Next-state and datapath decisions; every target defaults to holding.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    pend_next  = pend_reg;
    tgt_next   = tgt_reg;
`ifdef FETCH_TIMEOUT_EN
    cnt_next   = 8'd0;
    err_next   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // A branch wins over a fetch request in the same cycle.
        if (branch_taken) begin
          pc_next = branch_target;
        end else if (fetch_req && !stall) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (branch_taken) begin
          pend_next = 1'b1;
          tgt_next  = branch_target;
        end
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_rd_valid) begin
          // A branch arriving with the data is treated like a parked one,
          // so the redirect is never lost.
          if (pend_reg || branch_taken) begin
            pc_next    = branch_taken ? branch_target : tgt_reg;
            pend_next  = 1'b0;
            state_next = IDLE;
          end else begin
            instr_next = mem_rd_data;
            state_next = LOAD;
          end
        end else begin
          if (branch_taken) begin
            pend_next = 1'b1;
            tgt_next  = branch_target;
          end
`ifdef FETCH_TIMEOUT_EN
          // Give up on the read; pc stays put so it can be re-fetched.
          if (cnt_reg == TIMEOUT_CYCLES - 8'd1) begin
            err_next   = 1'b1;
            pend_next  = 1'b0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
`endif
        end
      end
      LOAD: begin
        // 16-bit add wraps FFFF to 0000 naturally.
        pc_next    = branch_taken ? branch_target : pc_reg + 16'd1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      instr_reg     <= 16'h0000;
      pend_reg      <= 1'b0;
      tgt_reg       <= 16'h0000;
      mem_rd_en_reg <= 1'b0;
      ir_load_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      pend_reg      <= pend_next;
      tgt_reg       <= tgt_next;
      mem_rd_en_reg <= (state_next == REQ);
      ir_load_reg   <= (state_next == LOAD);
      busy_reg      <= (state_next != IDLE);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Silent-WAIT counter and the one-cycle error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= 8'd0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
  assign fetch_error = err_reg;
`else
  assign fetch_error = 1'b0;
`endif

  // pc only changes outside REQ, so mem_addr can follow it directly.
  assign mem_addr       = pc_reg;
  assign pc_out         = pc_reg;
  assign mem_rd_en      = mem_rd_en_reg;
  assign instr_out      = instr_reg;
  assign ir_load_enable = ir_load_reg;
  assign fetch_busy     = busy_reg;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, 8'd255, WAIT cycles before a fetch is abandoned (used only with FETCH_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  input  1  control unit requests the next instruction.
REQ-006 stall  input  1  blocks a new fetch from starting.
REQ-007 branch_taken  input  1  redirects the PC to branch_target.
REQ-008 branch_target  input  16  redirect address.
REQ-009 mem_addr  output  16  instruction memory word address.
REQ-010 mem_rd_en  output  1  one-cycle memory read strobe.
REQ-011 mem_rd_valid  input  1  memory read data valid.
REQ-012 mem_rd_data  input  16  memory read data.
REQ-013 instr_out  output  16  fetched instruction, driving the instruction register data input.
REQ-014 ir_load_enable  output  1  one-cycle pulse, driving the instruction register load enable.
REQ-015 pc_out  output  16  current program counter.
REQ-016 fetch_busy  output  1  high in every state except IDLE.
REQ-017 fetch_error  output  1  one-cycle timeout pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT and LOAD, with all outputs registered.
REQ-019 IDLE: fetch_req=1 and stall=0 and branch_taken=0 SHALL move the FSM to REQ; otherwise it remains in IDLE.
REQ-020 IDLE: branch_taken=1 SHALL load pc <= branch_target and remain in IDLE, taking priority over fetch_req in the same cycle.
REQ-021 REQ: mem_rd_en=1 and mem_addr=pc for exactly one cycle, then the FSM SHALL move to WAIT.
REQ-022 mem_rd_valid SHALL be sampled only in WAIT and ignored in every other state.
REQ-023 WAIT: mem_rd_valid=1 SHALL capture instr_out <= mem_rd_data and move the FSM to LOAD, unless a branch is pending.
REQ-024 LOAD: ir_load_enable=1 for one cycle and pc <= pc+1, wrapping 16'hFFFF to 16'h0000, then the FSM SHALL move to IDLE.
REQ-025 LOAD: branch_taken=1 SHALL replace the increment with pc <= branch_target while still pulsing ir_load_enable.
REQ-026 REQ/WAIT: branch_taken=1 SHALL latch branch_target into a pending-branch register.
REQ-027 WAIT with a branch pending: on mem_rd_valid the data SHALL be discarded (no ir_load_enable, instr_out unchanged), pc <= latched target, pending flag cleared, and the FSM SHALL go to IDLE.
REQ-028 Minimum latency: fetch_req in cycle 0 gives mem_rd_en in cycle 1, valid accepted in cycle 2 at the earliest, and ir_load_enable in cycle 3.
REQ-029 pc_out SHALL equal pc at all times, and mem_addr SHALL hold pc outside REQ.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, pc=RESET_PC, instr_out=0, mem_rd_en=0, ir_load_enable=0, fetch_error=0, pending flag=0 and timeout counter=0.
REQ-031 A reset during WAIT SHALL abandon the fetch, and a later mem_rd_valid SHALL be ignored.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL count WAIT cycles without mem_rd_valid; reaching TIMEOUT_CYCLES SHALL pulse fetch_error for one cycle, clear the pending flag, keep pc unchanged and return the FSM to IDLE.
REQ-033 Without FETCH_TIMEOUT_EN, fetch_error SHALL be tied to 0, no counter SHALL exist, and WAIT SHALL hold indefinitely.

Verification
REQ-034 Reset, then fetch_req=1, memory returning 16'hA5C3 one cycle after mem_rd_en -> mem_addr=16'h0000, instr_out=16'hA5C3, ir_load_enable pulse in cycle 3, pc_out=16'h0001.
REQ-035 pc=16'hFFFF, single fetch completes -> pc_out=16'h0000.
REQ-036 branch_taken with target 16'h0040 in WAIT, then valid data 16'h1234 -> no ir_load_enable pulse, instr_out unchanged, pc_out=16'h0040, FSM in IDLE.
REQ-037 fetch_req=1 with stall=1 for 5 cycles -> no mem_rd_en; stall dropped -> mem_rd_en on the next cycle.
REQ-038 Reset asserted mid-WAIT, then mem_rd_valid -> no ir_load_enable pulse, pc_out=RESET_PC.
REQ-039 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, memory never responds -> fetch_error pulses after 4 WAIT cycles, FSM in IDLE, pc unchanged.
